// File: rtl/st_pkg.sv
// Shared op-code constants, FSM state encoding and memory command payload
// for the stack-pointer controller.
package st_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 8;

  localparam logic [OP_W-1:0] OP_NOP   = 8'h00;
  localparam logic [OP_W-1:0] OP_PUSH  = 8'h01;
  localparam logic [OP_W-1:0] OP_POP   = 8'h02;
  localparam logic [OP_W-1:0] OP_ADDSP = 8'h04;
  localparam logic [OP_W-1:0] OP_SUBSP = 8'h08;
  localparam logic [OP_W-1:0] OP_MOVSP = 8'h10;
  localparam logic [OP_W-1:0] OP_ADDS  = 8'h20;
  localparam logic [OP_W-1:0] OP_LDRSP = 8'h40;
  localparam logic [OP_W-1:0] OP_STRSP = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/st_addr_gen.sv
// Combinational next-SP / access-address generator with stack bound checks.
module st_addr_gen
  import st_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0000_1000,
  parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
  input  logic [DATA_W-1:0] sp,
  input  logic [OP_W-1:0]   op_sel,
  input  logic [6:0]        immed7,
  input  logic [7:0]        immed8,
  output logic [DATA_W-1:0] sp_next_c,
  output logic [DATA_W-1:0] addr_c,
  output logic              push_ovf_c,
  output logic              pop_unf_c
);

  logic [DATA_W-1:0] off7;
  logic [DATA_W-1:0] off8;
  logic [DATA_W-1:0] sp_dec;
  logic [DATA_W-1:0] sp_inc;
  logic              unused_imm;

  // Immediates are word offsets; upper bits are architecturally ignored.
  assign off7       = {25'd0, immed7[4:0], 2'b00};
  assign off8       = {24'd0, immed8[5:0], 2'b00};
  assign unused_imm = ^{immed7[6:5], immed8[7:6]};
  assign sp_dec     = sp - DATA_W'(4);
  assign sp_inc     = sp + DATA_W'(4);

  assign push_ovf_c = (sp_dec < SP_LIMIT);
  assign pop_unf_c  = (sp >= SP_RESET);

  always_comb begin
    sp_next_c = sp;
    addr_c    = sp;
    case (op_sel)
      OP_PUSH: begin
        sp_next_c = sp_dec;
        addr_c    = sp_dec;
      end
      OP_POP:   sp_next_c = sp_inc;
      OP_ADDSP: sp_next_c = sp + off7;
      OP_SUBSP: sp_next_c = sp - off7;
      OP_LDRSP, OP_STRSP, OP_ADDS: addr_c = sp + off8;
      default: ;
    endcase
  end

endmodule

// File: rtl/st_stack_ctrl.sv
// Stack-pointer controller: SP arithmetic ops plus push/pop/load/store
// through a single req/ack memory port, with sticky over/underflow flag.
module st_stack_ctrl
  import st_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0000_1000,
  parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_sel,
  input  logic [6:0]        immed7,
  input  logic [7:0]        immed8,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sp_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] sp_pend_q, sp_pend_d;
  logic              ready_q, ready_d;
  logic              req_q, req_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] sp_next_c;
  logic [DATA_W-1:0] addr_c;
  logic              push_ovf_c;
  logic              pop_unf_c;

  st_addr_gen #(
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_addr_gen (
    .sp         (sp_q),
    .op_sel     (op_sel),
    .immed7     (immed7),
    .immed8     (immed8),
    .sp_next_c  (sp_next_c),
    .addr_c     (addr_c),
    .push_ovf_c (push_ovf_c),
    .pop_unf_c  (pop_unf_c)
  );

  // Next-state and next-output logic; SP for push/pop is held pending until ack.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    sp_pend_d  = sp_pend_q;
    req_d      = req_q;
    cmd_d      = cmd_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_sel)
            OP_PUSH: begin
              if (push_ovf_c) begin
                err_d = 1'b1;
              end else begin
                state_d   = MEM;
                req_d     = 1'b1;
                cmd_d     = '{we: 1'b1, addr: addr_c, wdata: wr_data};
                sp_pend_d = sp_next_c;
              end
            end
            OP_POP: begin
              if (pop_unf_c) begin
                err_d = 1'b1;
              end else begin
                state_d   = MEM;
                req_d     = 1'b1;
                cmd_d     = '{we: 1'b0, addr: addr_c, wdata: cmd_q.wdata};
                sp_pend_d = sp_next_c;
              end
            end
            OP_LDRSP: begin
              state_d   = MEM;
              req_d     = 1'b1;
              cmd_d     = '{we: 1'b0, addr: addr_c, wdata: cmd_q.wdata};
              sp_pend_d = sp_q;
            end
            OP_STRSP: begin
              state_d   = MEM;
              req_d     = 1'b1;
              cmd_d     = '{we: 1'b1, addr: addr_c, wdata: wr_data};
              sp_pend_d = sp_q;
            end
            OP_ADDS: begin
              state_d    = RESP;
              rd_valid_d = 1'b1;
              rd_data_d  = addr_c;
            end
            OP_ADDSP, OP_SUBSP: sp_d = sp_next_c;
            OP_MOVSP:           sp_d = {wr_data[DATA_W-1:2], 2'b00};
            default: ;
          endcase
        end
      end
      MEM: begin
        if (mem_ack) begin
          sp_d  = sp_pend_q;
          req_d = 1'b0;
          if (cmd_q.we) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sp_q       <= SP_RESET;
      sp_pend_q  <= SP_RESET;
      ready_q    <= 1'b1;
      req_q      <= 1'b0;
      cmd_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      sp_pend_q  <= sp_pend_d;
      ready_q    <= ready_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign op_ready  = ready_q;
  assign sp_out    = sp_q;
  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_st_stack_ctrl.sv
// Self-checking bench for st_stack_ctrl: expected memory accesses and read
// results are queued when ops are issued and compared when the DUT produces them.
module tb_st_stack_ctrl;

  logic        clk;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_sel;
  logic [6:0]  immed7;
  logic [7:0]  immed8;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] sp_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;

  st_stack_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_sel    (op_sel),
    .immed7    (immed7),
    .immed8    (immed8),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .sp_out    (sp_out),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    mem_ack = 1'b0;
    op_valid = 1'b0;
    op_sel = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [6:0] i7,
                       input logic [7:0] i8, input logic [31:0] wd);
    @(negedge clk);
    op_valid = 1'b1;
    op_sel   = op;
    immed7   = i7;
    immed8   = i8;
    wr_data  = wd;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_sel   = 8'h00;
  endtask

  // Acts as the memory: checks the request against the queue, acks after delay cycles.
  task automatic mem_service(input int delay, input logic [31:0] rdata);
    mem_exp_t    e;
    logic [31:0] exp_rd;
    int          n;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_req_timeout: mem_req=%b required 1", mem_req);
      return;
    end
    checks++;
    if (mem_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_access: addr=%h with no access expected", mem_addr);
      return;
    end
    e = mem_q.pop_front();
    checks++;
    if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
      errors++;
      $display("FAIL mem_cmd: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
               mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
    end
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_we !== e.we) begin
      errors++;
      $display("FAIL mem_hold: req=%b addr=%h required req=1 addr=%h", mem_req, mem_addr, e.addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mem_req_fall: mem_req=%b required 0", mem_req);
    end
    if (!e.we) begin
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL rd_valid_rise: rd_valid=%b required 1", rd_valid);
      end
      if (rd_q.size() > 0) begin
        exp_rd = rd_q.pop_front();
        checks++;
        if (rd_data !== exp_rd) begin
          errors++;
          $display("FAIL rd_data: got %h required %h", rd_data, exp_rd);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (rd_valid !== 1'b0 || op_ready !== 1'b1) begin
        errors++;
        $display("FAIL rd_valid_pulse: rd_valid=%b op_ready=%b required 0/1", rd_valid, op_ready);
      end
    end else begin
      checks++;
      if (op_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_write: op_ready=%b required 1", op_ready);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({op_ready, mem_req, mem_we, rd_valid, err} !== 5'b10000 ||
        sp_out !== 32'h0000_1000 || mem_addr !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b req=%b we=%b rdv=%b err=%b sp=%h addr=%h rd=%h required 1/0/0/0/0 sp=1000",
               op_ready, mem_req, mem_we, rd_valid, err, sp_out, mem_addr, rd_data);
    end
  endtask

  task automatic test_push_pop();
    mem_q.push_back('{we: 1'b1, addr: 32'h0000_0FFC, wdata: 32'hDEAD_BEEF});
    issue(8'h01, 7'h0, 8'h0, 32'hDEAD_BEEF);
    checks++;
    if (sp_out !== 32'h0000_1000 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL push_pending: sp=%h ready=%b required sp=1000 ready=0", sp_out, op_ready);
    end
    mem_service(2, 32'h0);
    checks++;
    if (sp_out !== 32'h0000_0FFC) begin
      errors++;
      $display("FAIL push_sp: got %h required 00000ffc", sp_out);
    end
    mem_q.push_back('{we: 1'b0, addr: 32'h0000_0FFC, wdata: 32'h0});
    rd_q.push_back(32'hDEAD_BEEF);
    issue(8'h02, 7'h0, 8'h0, 32'h0);
    mem_service(1, 32'hDEAD_BEEF);
    checks++;
    if (sp_out !== 32'h0000_1000 || rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL pop_sp: sp=%h rd=%h required sp=1000 rd=deadbeef", sp_out, rd_data);
    end
  endtask

  task automatic test_underflow();
    issue(8'h02, 7'h0, 8'h0, 32'h0);
    checks++;
    if (mem_req !== 1'b0 || err !== 1'b1 || sp_out !== 32'h0000_1000 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_underflow: req=%b err=%b sp=%h ready=%b required 0/1/1000/1",
               mem_req, err, sp_out, op_ready);
    end
    issue(8'h00, 7'h0, 8'h0, 32'h0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    issue(8'h10, 7'h0, 8'h0, 32'h0000_0803);
    checks++;
    if (sp_out !== 32'h0000_0800) begin
      errors++;
      $display("FAIL movsp_align: got %h required 00000800", sp_out);
    end
    for (int k = 0; k < 2; k++) begin
      issue(8'h01, 7'h0, 8'h0, 32'h1111_0000 + 32'(k));
      checks++;
      if (mem_req !== 1'b0 || err !== 1'b1 || sp_out !== 32'h0000_0800) begin
        errors++;
        $display("FAIL push_overflow_%0d: req=%b err=%b sp=%h required 0/1/800", k, mem_req, err, sp_out);
      end
    end
    apply_reset();
    issue(8'h10, 7'h0, 8'h0, 32'h0000_0807);
    mem_q.push_back('{we: 1'b1, addr: 32'h0000_0800, wdata: 32'hA5A5_0001});
    issue(8'h01, 7'h0, 8'h0, 32'hA5A5_0001);
    mem_service(0, 32'h0);
    checks++;
    if (sp_out !== 32'h0000_0800 || err !== 1'b0) begin
      errors++;
      $display("FAIL push_to_limit: sp=%h err=%b required 800/0", sp_out, err);
    end
    issue(8'h01, 7'h0, 8'h0, 32'hA5A5_0002);
    checks++;
    if (mem_req !== 1'b0 || err !== 1'b1 || sp_out !== 32'h0000_0800) begin
      errors++;
      $display("FAIL push_past_limit: req=%b err=%b sp=%h required 0/1/800", mem_req, err, sp_out);
    end
  endtask

  task automatic test_sp_arith();
    logic [31:0] exp_rd;
    apply_reset();
    issue(8'h08, 7'h05, 8'h0, 32'h0);
    checks++;
    if (sp_out !== 32'h0000_0FEC || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL subsp: sp=%h req=%b required 00000fec/0", sp_out, mem_req);
    end
    mem_q.push_back('{we: 1'b0, addr: 32'h0000_0FF8, wdata: 32'h0});
    rd_q.push_back(32'h1234_5678);
    issue(8'h40, 7'h0, 8'h03, 32'h0);
    mem_service(1, 32'h1234_5678);
    mem_q.push_back('{we: 1'b1, addr: 32'h0000_10E8, wdata: 32'hCAFE_F00D});
    issue(8'h80, 7'h0, 8'hFF, 32'hCAFE_F00D);
    mem_service(3, 32'h0);
    checks++;
    if (sp_out !== 32'h0000_0FEC) begin
      errors++;
      $display("FAIL ldr_str_sp: got %h required 00000fec", sp_out);
    end
    rd_q.push_back(32'h0000_10E8);
    issue(8'h20, 7'h0, 8'h3F, 32'h0);
    exp_rd = rd_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_rd || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL adds: rdv=%b rd=%h req=%b required 1/%h/0", rd_valid, rd_data, mem_req, exp_rd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_rd || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL adds_hold: rdv=%b rd=%h ready=%b required 0/%h/1", rd_valid, rd_data, op_ready, exp_rd);
    end
    issue(8'h04, 7'h7F, 8'h0, 32'h0);
    issue(8'h03, 7'h01, 8'h01, 32'h0);
    checks++;
    if (sp_out !== 32'h0000_1068 || mem_req !== 1'b0 || rd_data !== exp_rd) begin
      errors++;
      $display("FAIL addsp_nonhot: sp=%h req=%b rd=%h required 00001068/0/%h", sp_out, mem_req, rd_data, exp_rd);
    end
    issue(8'h10, 7'h0, 8'h0, 32'h0000_0004);
    issue(8'h08, 7'h02, 8'h0, 32'h0);
    checks++;
    if (sp_out !== 32'hFFFF_FFFC || err !== 1'b0) begin
      errors++;
      $display("FAIL subsp_wrap: sp=%h err=%b required fffffffc/0", sp_out, err);
    end
  endtask

  task automatic test_reset_mid_mem();
    mem_exp_t e;
    apply_reset();
    mem_q.push_back('{we: 1'b1, addr: 32'h0000_0FFC, wdata: 32'h0BAD_0001});
    issue(8'h01, 7'h0, 8'h0, 32'h0BAD_0001);
    e = mem_q.pop_front();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
      errors++;
      $display("FAIL abort_pre: req=%b addr=%h wdata=%h required 1/%h/%h", mem_req, mem_addr, mem_wdata, e.addr, e.wdata);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || sp_out !== 32'h0000_1000 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_async: req=%b sp=%h ready=%b required 0/1000/1", mem_req, sp_out, op_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++;
    if (sp_out !== 32'h0000_1000 || mem_req !== 1'b0 || rd_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack: sp=%h req=%b rdv=%b ready=%b required 1000/0/0/1", sp_out, mem_req, rd_valid, op_ready);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    op_valid  = 1'b0;
    op_sel    = 8'h00;
    immed7    = 7'h0;
    immed8    = 8'h0;
    wr_data   = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_sp_arith();
    test_reset_mid_mem();
    checks++;
    if (mem_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: mem_q=%0d rd_q=%0d required 0/0", mem_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
